n0prime_calc: RTL and testbench

- Computes the Montgomery word constant for RSA modular multiplication.
- Given an odd modulus q (up to 1025 bits) and the word radix p (normally 2^32), it produces qinv = q^-1 mod p and real_output = (-q^-1) mod p, i.e. n0'.
- Sits in the RSA decryption datapath setup path and runs once per key load.
- Iterative bit-lifting engine: one bit per clock, using a 32x32 multiply.

---
 rtl/n0prime_calc.sv | 126 ++++++++++++
 tb/tb_n0prime_calc.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/n0prime_calc.sv
// Montgomery word constant engine: lifts q^-1 mod 2^k one bit per clock
// and reports qinv and n0' = -q^-1 mod p for the RSA setup path.
module n0prime_calc #(
   parameter int W  = 32,
   parameter int NW = 1025
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [NW-1:0] p,
   input  logic [NW-1:0] q,
   input  logic          start,
   output logic [W-1:0]  t,
   output logic [W-1:0]  qinv,
   output logic [W-1:0]  real_output,
   output logic          done
);

   localparam int IW = $clog2(W);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIN
   } state_t;

   state_t        state, state_n;
   logic [W-1:0]  y, y_n;
   logic [IW-1:0] idx, idx_n;
   logic [W-1:0]  qlo, qlo_n;
   logic [W-1:0]  mask, mask_n;
   logic [W:0]    plo, plo_n;
   logic [W-1:0]  t_n, qinv_n, real_n;
   logic          done_n;

   logic [2*W-1:0] prod_full;
   logic [W-1:0]   prod;
   logic [W-1:0]   ym;
   logic [W:0]     diff;

   logic unused_bits;
   assign unused_bits = ^{p[NW-1:W+1], q[NW-1:W]};

   // Only the low word of the product matters for the mod 2^32 invariant
   assign prod_full = {{W{1'b0}}, qlo} * {{W{1'b0}}, y};
   assign prod      = prod_full[W-1:0];
   assign ym        = y & mask;
   assign diff      = plo - {1'b0, ym};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         y           <= '0;
         idx         <= '0;
         qlo         <= '0;
         mask        <= '0;
         plo         <= '0;
         t           <= '0;
         qinv        <= '0;
         real_output <= '0;
         done        <= 1'b0;
      end else begin
         state       <= state_n;
         y           <= y_n;
         idx         <= idx_n;
         qlo         <= qlo_n;
         mask        <= mask_n;
         plo         <= plo_n;
         t           <= t_n;
         qinv        <= qinv_n;
         real_output <= real_n;
         done        <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      y_n     = y;
      idx_n   = idx;
      qlo_n   = qlo;
      mask_n  = mask;
      plo_n   = plo;
      t_n     = t;
      qinv_n  = qinv;
      real_n  = real_output;
      done_n  = done;
      unique case (state)
         IDLE: begin
            if (start) begin
               qlo_n   = q[W-1:0];
               plo_n   = p[W:0];
               mask_n  = p[W-1:0] - W'(1);
               y_n     = W'(1);
               idx_n   = IW'(1);
               done_n  = 1'b0;
               state_n = CALC;
            end
         end
         CALC: begin
            if (prod[idx]) begin
               y_n = y | (W'(1) << idx);
            end
            idx_n = idx + IW'(1);
            if (idx == IW'(W - 1)) begin
               state_n = FIN;
            end
         end
         FIN: begin
            // Even modulus has no inverse, so both results collapse to zero
            if (qlo[0]) begin
               qinv_n = ym;
               real_n = diff[W-1:0] & mask;
            end else begin
               qinv_n = '0;
               real_n = '0;
            end
            t_n     = qlo & mask;
            done_n  = 1'b1;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_n0prime_calc.sv
// Directed-vector bench for n0prime_calc with hand-computed results.
module tb_n0prime_calc;

   logic          clk;
   logic          rst;
   logic [1024:0] p;
   logic [1024:0] q;
   logic          start;
   logic [31:0]   t;
   logic [31:0]   qinv;
   logic [31:0]   real_output;
   logic          done;

   int checks = 0;
   int errors = 0;

   localparam logic [1024:0] P32 = 1025'd4294967296;

   n0prime_calc dut (
      .clk         (clk),
      .rst         (rst),
      .p           (p),
      .q           (q),
      .start       (start),
      .t           (t),
      .qinv        (qinv),
      .real_output (real_output),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Caller is positioned #1 after a rising edge
   task automatic run(input logic [1024:0] pv, input logic [1024:0] qv,
                      output int lat);
      p     = pv;
      q     = qv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 0;
      while (lat < 40 && !done) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   int            lat;
   logic [1024:0] big;
   logic [31:0]   qlo;
   logic [31:0]   old_qinv;

   initial begin
      big = 1025'd120438868727477310344120263029552552376337511996484512694347091974201763457850399669200822201471306702340516169733075299282219826573393614803261386878077831699751555200378540743659859996901651704593571074021593191781955291789478910485229539557955555100432691694387132173723677692188500922648867639674282419443;
      rst   = 1'b1;
      start = 1'b0;
      p     = P32;
      q     = 1025'd3;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_t", t, 32'h0);
      chk("rst_qinv", qinv, 32'h0);
      chk("rst_real", real_output, 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("idle_done", 32'(done), 32'h0);

      run(P32, 1025'd3, lat);
      chk("q3_lat", 32'(lat), 32'd32);
      chk("q3_qinv", qinv, 32'hAAAAAAAB);
      chk("q3_real", real_output, 32'h55555555);
      chk("q3_t", t, 32'h3);

      run(P32, 1025'd1, lat);
      chk("q1_qinv", qinv, 32'h1);
      chk("q1_real", real_output, 32'hFFFFFFFF);
      chk("q1_t", t, 32'h1);

      run(1025'd16, 1025'd7, lat);
      chk("p16_lat", 32'(lat), 32'd32);
      chk("p16_qinv", qinv, 32'h7);
      chk("p16_real", real_output, 32'h9);
      chk("p16_t", t, 32'h7);

      run(P32, big, lat);
      qlo = big[31:0];
      chk("rsa_inv", qlo * qinv, 32'h1);
      chk("rsa_sum", qinv + real_output, 32'h0);
      chk("rsa_t", t, qlo);

      run(P32, 1025'd4, lat);
      chk("even_done", 32'(done), 32'h1);
      chk("even_qinv", qinv, 32'h0);
      chk("even_real", real_output, 32'h0);
      chk("even_t", t, 32'h4);

      // New start clears done but holds old outputs; a mid-CALC start is ignored
      old_qinv = qinv;
      p        = P32;
      q        = 1025'd3;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("restart_done", 32'(done), 32'h0);
      chk("restart_hold_t", t, 32'h4);
      chk("restart_hold_q", qinv, old_qinv);
      repeat (9) @(posedge clk);
      #1;
      q     = 1025'd5;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      q     = 1025'd3;
      lat   = 10;
      while (lat < 40 && !done) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("ign_lat", 32'(lat), 32'd32);
      chk("ign_qinv", qinv, 32'hAAAAAAAB);
      chk("ign_real", real_output, 32'h55555555);

      // Reset at cycle 10 of CALC
      p     = P32;
      q     = 1025'd7;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_done", 32'(done), 32'h0);
      chk("abort_qinv", qinv, 32'h0);
      chk("abort_real", real_output, 32'h0);
      chk("abort_t", t, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("abort_idle", 32'(done), 32'h0);

      run(1025'd16, 1025'd7, lat);
      chk("post_lat", 32'(lat), 32'd32);
      chk("post_qinv", qinv, 32'h7);
      chk("post_real", real_output, 32'h9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
